// File: rtl/div_ctrl.sv
// div_ctrl: iterative radix-2 restoring divider controller for DIV/DIVU.
// Returns {remainder, quotient} after 33 cycles and stalls the pipe meanwhile.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic               start,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH:0]   w_partial;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;

    assign w_accept = start && !annul;
    assign w_zero   = (opdata2 == '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    assign w_mag1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign w_mag2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // Dividend bits shift out of the quotient register's MSB as quotient bits shift in.
    assign w_partial = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_partial >= {1'b0, r_div});
    assign w_sub     = w_partial[WIDTH-1:0] - r_div;
    assign w_rem_nx  = w_ge ? w_sub : w_partial[WIDTH-1:0];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};

    assign w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

    assign ready     = (r_state == S_END) && !rst;
    assign stall_req = !rst && (r_state != S_END)
                       && ((r_state != S_FREE) || w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FREE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                w_next = annul ? S_FREE : S_END;
            end
            S_ON: begin
                if (annul) begin
                    w_next = S_FREE;
                end else if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                w_next = S_FREE;
            end
            default: begin
                w_next = S_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            result  <= '0;
        end else begin
            unique case (r_state)
                S_FREE: begin
                    if (w_accept && !w_zero) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_mag1;
                        r_div   <= w_mag2;
                        r_neg_q <= signed_div
                                   && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        r_neg_r <= signed_div && opdata1[WIDTH-1];
                    end
                end
                S_BYZERO: begin
                    if (!annul) begin
                        result <= '0;
                    end
                end
                S_ON: begin
                    if (!annul) begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed tests for div_ctrl with hand-computed results.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_div_ctrl;
    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               signed_div;
    logic               start;
    logic               annul;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_req;

    int total;
    int bad;

    div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .start      (start),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and reports latency to ready, stall cycles and result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, output logic [63:0] res,
                          output int lat, output int stalls);
        lat    = -1;
        stalls = 0;
        res    = '0;
        @(posedge clk); #1;
        start      = 1'b1;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            if (ready) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b1;
        opdata1 = 32'd9;
        opdata2 = 32'd3;
        @(negedge clk);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", ready);
        end
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b want=0", stall_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (result !== 64'd0) begin
            bad++;
            $display("FAIL reset_result got=%h want=0", result);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got stall=%b ready=%b want 0/0",
                     stall_req, ready);
        end
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        int st;
        run_op(32'd100, 32'd7, 1'b0, res, lat, st);
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL unsigned_latency got=%0d want=33", lat);
        end
        total++;
        if (st !== 33) begin
            bad++;
            $display("FAIL unsigned_stall_cycles got=%0d want=33", st);
        end
        total++;
        if (res !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL unsigned_100_7 got=%h want=%h", res, {32'd2, 32'd14});
        end
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, res, lat, st);
        total++;
        if (res !== {32'd0, 32'hFFFF_FFFF}) begin
            bad++;
            $display("FAIL unsigned_max_1 got=%h", res);
        end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat;
        int st;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, st);
        total++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            bad++;
            $display("FAIL signed_m7_2 got=%h want=ffffffff_fffffffd", res);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL signed_latency got=%0d want=33", lat);
        end
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, res, lat, st);
        total++;
        if (res !== {32'd1, 32'hFFFF_FFFD}) begin
            bad++;
            $display("FAIL signed_7_m2 got=%h want=00000001_fffffffd", res);
        end
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, res, lat, st);
        total++;
        if (res !== {32'hFFFF_FFFE, 32'd14}) begin
            bad++;
            $display("FAIL signed_m100_m7 got=%h want=fffffffe_0000000e", res);
        end
    endtask

    task automatic test_edge();
        logic [63:0] res;
        int lat;
        int st;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, st);
        total++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            bad++;
            $display("FAIL edge_signed_wrap got=%h want=00000000_80000000", res);
        end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res, lat, st);
        total++;
        if (res !== {32'h8000_0000, 32'd0}) begin
            bad++;
            $display("FAIL edge_unsigned got=%h want=80000000_00000000", res);
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat;
        int st;
        run_op(32'd5, 32'd0, 1'b0, res, lat, st);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL divzero_latency got=%0d want=2", lat);
        end
        total++;
        if (st !== 2) begin
            bad++;
            $display("FAIL divzero_stall_cycles got=%0d want=2", st);
        end
        total++;
        if (res !== 64'd0) begin
            bad++;
            $display("FAIL divzero_unsigned got=%h want=0", res);
        end
        run_op(32'd40, 32'd3, 1'b0, res, lat, st);
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, res, lat, st);
        total++;
        if (res !== 64'd0 || lat !== 2) begin
            bad++;
            $display("FAIL divzero_signed got=%h lat=%0d want=0 lat=2", res, lat);
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        int st;
        int rdy;
        run_op(32'd50, 32'd3, 1'b0, res, lat, st);
        @(posedge clk); #1;
        start   = 1'b1;
        opdata1 = 32'd1000;
        opdata2 = 32'd10;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        annul = 1'b1;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL annul_cycle got stall=%b ready=%b want 1/0",
                     stall_req, ready);
        end
        @(posedge clk); #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL annul_free_stall got=%b want=0", stall_req);
        end
        rdy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) rdy++;
        end
        total++;
        if (rdy !== 0) begin
            bad++;
            $display("FAIL annul_no_ready got=%0d ready cycles want=0", rdy);
        end
        total++;
        if (result !== {32'd2, 32'd16}) begin
            bad++;
            $display("FAIL annul_result_held got=%h want=00000002_00000010", result);
        end
        @(posedge clk); #1;
        start = 1'b1;
        annul = 1'b1;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL annul_with_start got=%b want=0", stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL annul_start_ignored got stall=%b ready=%b want 0/0",
                     stall_req, ready);
        end
    endtask

    task automatic test_rst_abort();
        @(posedge clk); #1;
        start   = 1'b1;
        opdata1 = 32'd77;
        opdata2 = 32'd5;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_cycle got stall=%b ready=%b want 0/0",
                     stall_req, ready);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL rst_abort got stall=%b result=%h want 0/0",
                     stall_req, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        logic        st0;
        int lat;
        int st;
        run_op(32'd1000, 32'd10, 1'b0, res, lat, st);
        total++;
        if (res !== {32'd0, 32'd100}) begin
            bad++;
            $display("FAIL b2b_first got=%h want=00000000_00000064", res);
        end
        start      = 1'b1;
        signed_div = 1'b1;
        opdata1    = 32'hFFFF_FC18;
        opdata2    = 32'd7;
        lat = -1;
        st0 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (c == 5) start = 1'b0;
            @(negedge clk);
            if (c == 0) st0 = stall_req;
            if (ready) begin
                lat = c;
                res = result;
                break;
            end
        end
        start = 1'b0;
        total++;
        if (st0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept_stall got=%b want=1", st0);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=33", lat);
        end
        total++;
        if (res !== {32'hFFFF_FFFA, 32'hFFFF_FF72}) begin
            bad++;
            $display("FAIL b2b_second got=%h want=fffffffa_ffffff72", res);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_edge();
        test_div_zero();
        test_annul();
        test_rst_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
